// File: rtl/io_port_unit_pkg.sv
// Shared defaults and sizing helper for the processor I/O port unit.
package io_port_unit_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_TX_DEPTH = 4;
  localparam int DEF_RX_DEPTH = 4;

  // Occupancy counters need one extra bit so that level==DEPTH is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_port_unit_fifo.sv
// Generic first-word-fall-through FIFO with occupancy counter; full/empty are
// taken from registered level only, so same-cycle push/pop never rescue each other.
module io_fifo
  import io_port_unit_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [lvl_w(DEPTH)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];
  assign o_level   = r_level;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push && !reset) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// Pipeline IN/OUT port: TX and RX FIFOs bridged to external valid/ready channels,
// with a combinational stall when the requested FIFO cannot serve this cycle.
module io_port_unit
  import io_port_unit_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TX_DEPTH = DEF_TX_DEPTH,
  parameter int RX_DEPTH = DEF_RX_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_out_en,
  input  logic [DATA_W-1:0]        cpu_out_data,
  input  logic                     cpu_in_en,
  output logic [DATA_W-1:0]        cpu_in_data,
  output logic                     cpu_stall,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level
);

  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  // Both handshakes are masked while reset is high so no transfer completes
  // on a cycle whose queued words are being discarded.
  assign tx_valid  = !reset && !w_tx_empty;
  assign rx_ready  = !reset && !w_rx_full;

  assign w_tx_push = cpu_out_en && !w_tx_full;
  assign w_tx_pop  = tx_valid && tx_ready;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = cpu_in_en && !w_rx_empty;

  assign cpu_stall = (cpu_out_en && w_tx_full) || (cpu_in_en && w_rx_empty);

  io_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_wdata (cpu_out_data),
    .i_pop   (w_tx_pop),
    .o_head  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  io_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_wdata (rx_data),
    .i_pop   (w_rx_pop),
    .o_head  (cpu_in_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (rx_level)
  );

endmodule
